// File: rtl/mux6_arb_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the
// six-way round-robin mux arbiter.
package mux6_arb_pkg;

  localparam int NUM_REQ = 6;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux6_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request searching upward
// from (pointer+1) mod 6, wrapping around.
module rr_pick
  import mux6_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   pointer,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic [SEL_W-1:0] cand [NUM_REQ];

  // cand[gi] is the requester examined at search distance gi+1 from pointer
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [SEL_W:0] sum;
    assign sum      = {1'b0, pointer} + (SEL_W+1)'(gi + 1);
    assign cand[gi] = (sum >= (SEL_W+1)'(NUM_REQ)) ? SEL_W'(sum - (SEL_W+1)'(NUM_REQ))
                                                   : SEL_W'(sum);
  end

  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) winner = cand[k];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 6:1 mux with hold limit.
// Define MUX6_ARB_HIPRI0_EN to make requester 0 high priority.
module mux6_rr_arbiter
  import mux6_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int NUM_REQ  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  if (NUM_REQ != mux6_arb_pkg::NUM_REQ) begin : g_bad_num_req
    $error("mux6_rr_arbiter: NUM_REQ must be 6");
  end

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_HOLD - 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   rr_winner;
  logic               rr_any;
  logic [SEL_W-1:0]   winner;
  logic               any_req;
  logic               upd_ptr;

`ifdef MUX6_ARB_HIPRI0_EN
  // Requester 0 bypasses the rotation; the rest rotate among themselves.
  assign pick_req = {req[NUM_REQ-1:1], 1'b0};
  assign winner   = req[0] ? '0 : rr_winner;
  assign any_req  = req[0] | rr_any;
  assign upd_ptr  = !req[0];
`else
  assign pick_req = req;
  assign winner   = rr_winner;
  assign any_req  = rr_any;
  assign upd_ptr  = 1'b1;
`endif

  rr_pick u_rr_pick (
    .req     (pick_req),
    .pointer (ptr_q),
    .winner  (rr_winner),
    .any_req (rr_any)
  );

  logic normal_rel;
  logic limit_hit;
  logic release_now;

  assign normal_rel  = done | ~req[sel_q];
  assign limit_hit   = (MAX_HOLD != 0) && (cnt_q == CNT_LIM);
  assign release_now = normal_rel | limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= idx2onehot(winner);
            sel_q   <= winner;
            if (upd_ptr) ptr_q <= winner;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (release_now) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            // Pulse only when the hold limit is the sole reason to let go
            timeout_q <= limit_hit & ~normal_rel;
            state_q   <= GAP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/mux6_rr_arbiter.md
Name: mux6_rr_arbiter

Overview:
- Round-robin arbiter that shares the team's six-input, 3-bit-select output mux among six requesters.
- Drives the mux select `sel` and a one-hot grant.
- Holds each grant until the owner signals completion, drops its request, or exceeds a hold limit.
- Sits directly in front of the 6:1 mux; `sel` connects straight to the mux's S input.

Parameters:
- MAX_HOLD, 15, maximum cycles a grant is held before forced release; 0 disables the timeout.
- NUM_REQ, 6, number of requesters; fixed at 6, and other values are illegal (elaboration error).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req  input  6  per-requester request, level.
- done  input  1  owner's transfer-complete pulse; ignored unless in HOLD.
- grant  output  6  one-hot grant, registered; all zero when no owner.
- sel  output  3  mux select; encodes the current/last owner; only values 0..5.
- busy  output  1  high while in HOLD.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset values (async assert, sync deassert by the integrator):
  - grant = 0, sel = 3'd0, busy = 0, timeout = 0, state = IDLE.
  - Last-owner pointer = 5, so requester 0 wins first.
  - Hold counter = 0.
- IDLE:
  - If req != 0, pick the first set bit searching from (pointer+1) mod 6 upward with wrap.
  - Next cycle: grant = onehot(winner), sel = winner, pointer = winner, busy = 1, state = HOLD.
  - Grant latency from req to grant is 1 cycle.
- HOLD: the hold counter increments each cycle, saturating at MAX_HOLD. Release occurs when any of these hold:
  - done = 1.
  - req[owner] = 0.
  - MAX_HOLD != 0 and counter == MAX_HOLD-1 (grant held exactly MAX_HOLD cycles).
- On release:
  - Next cycle: grant = 0, busy = 0, counter = 0, state = GAP.
  - timeout = 1 for that cycle only if the release cause was the limit alone.
- Simultaneous release causes: done or req drop together with the limit counts as normal release, with no timeout pulse.
- GAP:
  - One dead cycle with grant = 0; sel keeps the last owner so the mux output stays stable.
  - Unconditional transition to IDLE.
  - Minimum spacing between grants is therefore release cycle + GAP + IDLE.
- sel changes only on the IDLE->HOLD transition and never takes values 6 or 7.
- Requests arriving during HOLD/GAP wait; none are lost while held high.
- done outside HOLD: no effect.
- Reset asserted mid-HOLD: immediate return to reset values; the pending owner is forgotten.
- Fairness: a requester held continuously high is granted within 6 arbitration rounds.

Optional Feature:
- Macro: MUX6_ARB_HIPRI0_EN.
- Defined:
  - Requester 0 is high priority. In IDLE, if req[0] = 1 it wins regardless of pointer, and the pointer is not updated by a requester-0 grant.
  - The other five requesters keep round-robin among themselves.
- Undefined: pure round-robin over all six as above.

Decomposition:
- Package mux6_arb_pkg holds:
  - NUM_REQ = 6 and SEL_W = 3.
  - State enum {IDLE, HOLD, GAP}, 2 bits.
  - A function converting index to one-hot.
- One natural sub-module: rr_pick. It is a combinational rotate-priority encoder with inputs req[5:0] and pointer[2:0], and outputs winner[2:0] and any_req. It is instantiated once.

Test Plan:
- Reset then req = 6'b000001 → grant = 000001 and sel = 0 one cycle later, busy = 1; done pulse → grant = 0 next cycle, one GAP cycle follows.
- req = 6'b111111 held, done pulsed 2 cycles after each grant → grant order 0,1,2,3,4,5,0 with sel matching, one GAP between each.
- MAX_HOLD = 4, req = 6'b000100 held, no done → grant[2] high exactly 4 cycles, then timeout = 1 for one cycle, grant = 0; re-granted to 2 after GAP+IDLE.
- Owner 3 drops req mid-hold while req[5] = 1 → release, no timeout, next grant goes to 5; sel holds 3 through GAP.
- done and limit in the same cycle → release with timeout = 0; rst_n low mid-HOLD → all outputs to reset values asynchronously, first post-reset grant goes to requester 0 when req = 6'b111111.
- With MUX6_ARB_HIPRI0_EN and req = 6'b100001 continuously, done each grant → requester 0 granted every round; without the macro, grants alternate 0,5,0,5.
